// File: rtl/square_wave_freq_meter_pkg.sv
// Shared constants and state encoding for the square-wave frequency meter.
package freq_meter_pkg;

  localparam int unsigned CLOCK_FREQUENCY_DEF = 50_000_000;
  localparam int unsigned FREQ_W_DEF          = 16;
  localparam logic [FREQ_W_DEF-1:0] FREQ_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } meter_state_e;

endpackage

// File: rtl/square_wave_freq_meter_if.sv
// Signal bundle between the frequency meter and its consumer.
// master: the meter (samples sq_in, drives the result); slave: the consumer.
interface square_wave_freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int unsigned FREQ_W = FREQ_W_DEF
);
  logic              sq_in;
  logic [FREQ_W-1:0] freq_out;
  logic              freq_valid;
  logic              locked;
  logic              overrun;

  modport master (input sq_in, output freq_out, freq_valid, locked, overrun);
  modport slave  (output sq_in, input freq_out, freq_valid, locked, overrun);
endinterface

// File: rtl/square_wave_freq_meter_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W-cycle latency.
// done_o and quot_o are valid together during the final iteration cycle.
module seq_divider #(
  parameter int unsigned W = 26
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quot_o
);
  localparam int unsigned IW = $clog2(W);

  logic          busy_q;
  logic [IW-1:0] iter_q;
  logic [W-1:0]  rem_q, quo_q, div_q;
  logic [W:0]    rem_sh_d;
  logic          ge_d;
  logic [W-1:0]  rem_d, quo_d;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_sh_d = {rem_q, quo_q[W-1]};
    ge_d     = (rem_sh_d >= {1'b0, div_q});
    rem_d    = ge_d ? W'(rem_sh_d - {1'b0, div_q}) : rem_sh_d[W-1:0];
    quo_d    = {quo_q[W-2:0], ge_d};
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (iter_q == IW'(W - 1));
  assign quot_o = quo_d;

  // Load on an accepted start, then iterate until the last quotient bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      iter_q <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      div_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      iter_q <= iter_q + IW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/square_wave_freq_meter.sv
// Square-wave frequency meter: times the interval between input edges and
// reports floor(CLOCK_FREQUENCY / half_period) saturated to FREQ_W bits.
// Optional macro FREQ_METER_AVG_EN: average four intervals per result.
module square_wave_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEF,
  parameter int unsigned CNT_W           = 26,
  parameter int unsigned FREQ_W          = FREQ_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000
) (
  input logic                      clk,
  input logic                      reset_n,
  square_wave_freq_meter_if.master bus
);
  logic              sync1_q, sync_q, prev_q;
  meter_state_e      state_q;
  logic [CNT_W-1:0]  count_q;
  logic [FREQ_W-1:0] freq_q;
  logic              valid_q, locked_q, overrun_q;

  logic              edge_d, timeout_d, div_start_d;
  logic [CNT_W-1:0]  count_inc_d, captured_d, divisor_d;
  logic [FREQ_W-1:0] freq_sat_d;
  logic              div_busy, div_done;
  logic [CNT_W-1:0]  div_quot;

`ifdef FREQ_METER_AVG_EN
  logic [CNT_W+1:0]  acc_q, acc_sum_d;
  logic [1:0]        idx_q;
`endif

  // Two-flop synchronizer plus previous-value register for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.sq_in;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  // Edge, counter, timeout, divider launch and result saturation.
  always_comb begin
    edge_d      = sync_q ^ prev_q;
    count_inc_d = (&count_q) ? count_q : count_q + 1'b1;
    captured_d  = count_q + 1'b1;
    timeout_d   = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef FREQ_METER_AVG_EN
    acc_sum_d   = acc_q + {2'b00, captured_d};
    div_start_d = (state_q == MEASURE) && edge_d && (idx_q == 2'd3) && !div_busy;
    divisor_d   = acc_sum_d[CNT_W+1:2];
`else
    div_start_d = (state_q == MEASURE) && edge_d && !div_busy;
    divisor_d   = captured_d;
`endif
    freq_sat_d  = (|div_quot[CNT_W-1:FREQ_W]) ? '1 : div_quot[FREQ_W-1:0];
  end

  seq_divider #(.W(CNT_W)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (div_start_d),
    .dividend_i(CNT_W'(CLOCK_FREQUENCY)),
    .divisor_i (divisor_d),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot)
  );

  // Measurement FSM with registered result, lock and overrun outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      acc_q     <= '0;
      idx_q     <= '0;
`endif
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          count_q <= '0;
          if (edge_d) state_q <= MEASURE;
        end
        MEASURE: begin
          if (edge_d) begin
            count_q <= '0;
`ifdef FREQ_METER_AVG_EN
            if (idx_q == 2'd3) begin
              state_q <= DIVIDE;
              acc_q   <= '0;
              idx_q   <= '0;
            end else begin
              acc_q   <= acc_sum_d;
              idx_q   <= idx_q + 2'd1;
            end
`else
            state_q <= DIVIDE;
`endif
          end else if (timeout_d) begin
            count_q  <= '0;
            freq_q   <= '0;
            valid_q  <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= IDLE;
`ifdef FREQ_METER_AVG_EN
            acc_q    <= '0;
            idx_q    <= '0;
`endif
          end else begin
            count_q <= count_inc_d;
          end
        end
        DIVIDE: begin
          // An edge here is dropped, but it still restarts interval timing.
          if (edge_d) begin
            count_q   <= '0;
            overrun_q <= 1'b1;
`ifdef FREQ_METER_AVG_EN
            acc_q     <= '0;
            idx_q     <= '0;
`endif
          end else begin
            count_q <= count_inc_d;
          end
          if (div_done) begin
            freq_q   <= freq_sat_d;
            valid_q  <= 1'b1;
            locked_q <= 1'b1;
            state_q  <= MEASURE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.freq_out   = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.locked     = locked_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/square_wave_freq_meter.md
Name: square_wave_freq_meter

Overview:
- Receive-side counterpart of the synth's square-wave oscillators.
- Measures the interval between consecutive edges (rising or falling) of an asynchronous square-wave input and recovers the 16-bit frequency code that produced it: freq = floor(CLOCK_FREQUENCY / half_period_cycles).
- Used for oscillator loopback self-test and for tuning readout.
- Feeds the 16-bit frequency bus used by the wave generators.

Parameters:
- CLOCK_FREQUENCY, 50000000, system clock in Hz; the dividend constant.
- CNT_W, 26, half-period counter and divider width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- FREQ_W, 16, output code width.
- TIMEOUT_CYCLES, 50000000, cycles without an edge before reporting 0 Hz; must be greater than CNT_W+2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sq_in  in  1  asynchronous square-wave input
- freq_out  out  FREQ_W  last measured frequency code
- freq_valid  out  1  one-cycle pulse when freq_out updates
- locked  out  1  high after the first valid measurement; low after a timeout or reset
- overrun  out  1  one-cycle pulse when an edge arrives while the divider is busy

Behaviour:
- Reset: clock-edge sampled, all-synchronous. Clears the synchronizer flops and edge register to 0, freq_out=0, freq_valid=0, locked=0, overrun=0, count=0, state IDLE, divider idle. Reset mid-measurement or mid-divide abandons the operation; no freq_valid follows.
- Input path: 2-FF synchronizer plus a previous-value register. edge = sync_q XOR prev_q. The edge pulse is high 3 clk cycles after an sq_in transition.
- States:
  - IDLE: waiting for the first edge. count is held at 0. On edge go to MEASURE with count=0. No result is produced.
  - MEASURE: count increments each cycle, saturating at 2^CNT_W-1.
    - On an edge in cycle E: captured = count+1, count resets to 0, go to DIVIDE. The divider starts at E+1.
    - If count reaches TIMEOUT_CYCLES-1 with no edge: freq_out=0, freq_valid pulses, locked=0, go to IDLE.
    - Edge and timeout in the same cycle: edge wins.
  - DIVIDE: count keeps running from the edge. The divider runs CNT_W iterations (restoring, 1 bit per cycle) on dividend CLOCK_FREQUENCY and divisor captured.
    - At cycle E+CNT_W+1: freq_out = min(quotient, 2^FREQ_W-1), freq_valid=1 for one cycle, locked=1, return to MEASURE.
    - An edge during DIVIDE: overrun pulses in that same cycle, the new interval is discarded, count resets to 0, and the divide in progress completes normally.
- captured is never 0, so divide-by-zero is unreachable. Quotients above 65535 saturate to 16'hFFFF.
- Counter wrap: saturation makes wrap impossible; timeout always fires first.
- freq_out holds its value between updates.

Optional Feature:
- Macro: FREQ_METER_AVG_EN
- Defined: captured intervals are accumulated in a (CNT_W+2)-bit sum over 4 consecutive edges. The divisor is sum>>2, and a result is produced every 4th edge. The first result after IDLE needs 5 edges. Timeout, overrun and reset clear the accumulator and its 2-bit edge index.
- Undefined: a result is produced for every edge after the first, as described above.

Decomposition:
- Package freq_meter_pkg holds:
  - CLOCK_FREQUENCY default
  - FREQ_W
  - the state encoding IDLE/MEASURE/DIVIDE
  - FREQ_MAX = 2^FREQ_W-1
- Sub-module seq_divider: unsigned restoring divider, CNT_W-cycle latency, start/busy/done handshake. start is accepted only when not busy; done is a one-cycle pulse.
- Synchronizer and edge detect stay inline.

Test Plan:
- Toggle sq_in every 50000 cycles -> after the second edge, freq_valid pulses CNT_W+1 cycles after the edge pulse; freq_out=1000; locked=1.
- Toggle every 763 cycles -> freq_out=65530. Toggle every 700 cycles -> freq_out=65535 (saturated).
- With TIMEOUT_CYCLES=100000, toggle every 50000 cycles, then hold sq_in -> freq_out=0 and freq_valid pulse 100000 cycles after the last edge; locked=0. Resume toggling -> no result on the first edge, result on the second.
- After one edge, toggle every 10 cycles -> overrun pulses on each edge that lands in DIVIDE. The first completed divide reports floor(50e6/10)=5000000, saturated to 65535.
- Assert reset_n=0 for 1 cycle mid-DIVIDE -> no freq_valid from the aborted divide; freq_out=0, locked=0; the next result needs two fresh edges.
- With FREQ_METER_AVG_EN, intervals 1000,1000,1000,1004 (sum 4004, >>2 = 1001) -> one result after the 5th edge: freq_out=49950.
